// File: rtl/mac_pkg.sv
// Shared widths, accumulator limits and the saturating-add helper for the
// pipelined multi-channel MAC array.
package mac_pkg;

    localparam int ACC_W_DEF = 32;

    localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    typedef struct packed {
        logic signed [ACC_W_DEF-1:0] value;
        logic                        ovf;
    } sat_res_t;

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int sum_w(input int data_w, input int n_macs);
        return 2 * data_w + $clog2(n_macs);
    endfunction

    // Overflow shows up as disagreement between the extra top bit and the ACC_W sign bit.
    function automatic sat_res_t sat_add(input logic signed [ACC_W_DEF:0] wide,
                                         input logic sat_en);
        sat_res_t r;
        r.ovf = wide[ACC_W_DEF] != wide[ACC_W_DEF-1];
        if (r.ovf && sat_en)
            r.value = wide[ACC_W_DEF] ? ACC_MIN : ACC_MAX;
        else
            r.value = wide[ACC_W_DEF-1:0];
        return r;
    endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// One output channel: N_MACS full-precision multipliers (S1) feeding an exact
// adder tree whose result is registered (S2). Both stages hold on stall.
module mac_lane_tree
    import mac_pkg::*;
#(
    parameter int N_MACS = 16,
    parameter int DATA_W = 8
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     stall,
    input  logic [N_MACS*DATA_W-1:0]                 ifmap,
    input  logic [N_MACS*DATA_W-1:0]                 weight,
    output logic signed [sum_w(DATA_W, N_MACS)-1:0]  sum
);

    localparam int PROD_W = prod_w(DATA_W);
    localparam int SUM_W  = sum_w(DATA_W, N_MACS);

    logic signed [DATA_W-1:0] act_lane [N_MACS];
    logic signed [DATA_W-1:0] wgt_lane [N_MACS];
    logic signed [PROD_W-1:0] prod     [N_MACS];
    logic signed [SUM_W-1:0]  tree_sum;

    always_comb begin
        for (int unsigned i = 0; i < N_MACS; i++) begin
            act_lane[i] = ifmap[i*DATA_W +: DATA_W];
            wgt_lane[i] = weight[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int unsigned i = 0; i < N_MACS; i++)
            tree_sum = tree_sum + SUM_W'(prod[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_MACS; i++)
                prod[i] <= '0;
            sum <= '0;
        end else if (!stall) begin
            for (int unsigned i = 0; i < N_MACS; i++)
                prod[i] <= PROD_W'(act_lane[i]) * PROD_W'(wgt_lane[i]);
            sum <= tree_sum;
        end
    end

endmodule

// File: rtl/mac_array_pipe.sv
// Pipelined N_CH-channel MAC array: shared ifmap vector, per-channel weights,
// frame accumulation seeded by bias, saturation/ReLU and a backpressured output.
module mac_array_pipe
    import mac_pkg::*;
#(
    parameter int N_MACS = 16,
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_first,
    input  logic                            in_last,
    input  logic [N_MACS*DATA_W-1:0]        ifmap,
    input  logic [N_CH*N_MACS*DATA_W-1:0]   weight,
    input  logic [N_CH*ACC_W-1:0]           bias,
    input  logic                            sat_en,
    input  logic                            relu_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_CH*ACC_W-1:0]           out_acc,
    output logic                            out_ovf,
    output logic                            proto_err
);

    localparam int SUM_W = sum_w(DATA_W, N_MACS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OPEN = 1'b1;

    logic                      stall;
    logic                      accept;
    logic                      v1, v2;
    logic                      first1, first2, last1, last2;
    logic [N_CH*ACC_W-1:0]     bias1, bias2;
    logic signed [SUM_W-1:0]   lane_sum [N_CH];

    logic [0:0]                frame_state;
    logic signed [ACC_W-1:0]   acc      [N_CH];
    logic                      frame_ovf;

    logic signed [ACC_W-1:0]   base     [N_CH];
    logic signed [ACC_W-1:0]   new_acc  [N_CH];
    logic signed [ACC_W-1:0]   res      [N_CH];
    sat_res_t                  sr;
    logic                      beat_ovf;
    logic                      beat_err;
    logic                      frame_ovf_next;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        mac_lane_tree #(
            .N_MACS (N_MACS),
            .DATA_W (DATA_W)
        ) u_tree (
            .clk     (clk),
            .reset_n (reset_n),
            .stall   (stall),
            .ifmap   (ifmap),
            .weight  (weight[c*N_MACS*DATA_W +: N_MACS*DATA_W]),
            .sum     (lane_sum[c])
        );
    end

    // A misplaced first restarts from bias; a stray continuation beat starts from zero.
    always_comb begin
        sr       = '0;
        beat_ovf = 1'b0;
        beat_err = first2 ? (frame_state == ST_OPEN) : (frame_state == ST_IDLE);
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (first2)
                base[c] = bias2[c*ACC_W +: ACC_W];
            else if (frame_state == ST_OPEN)
                base[c] = acc[c];
            else
                base[c] = '0;
            sr         = sat_add({base[c][ACC_W-1], base[c]} + (ACC_W+1)'(lane_sum[c]), sat_en);
            new_acc[c] = sr.value;
            beat_ovf   = beat_ovf | sr.ovf;
            res[c]     = (relu_en && new_acc[c][ACC_W-1]) ? '0 : new_acc[c];
        end
        frame_ovf_next = (first2 ? 1'b0 : frame_ovf) | beat_ovf;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            first1      <= 1'b0;
            first2      <= 1'b0;
            last1       <= 1'b0;
            last2       <= 1'b0;
            bias1       <= '0;
            bias2       <= '0;
            frame_state <= ST_IDLE;
            frame_ovf   <= 1'b0;
            for (int unsigned c = 0; c < N_CH; c++)
                acc[c] <= '0;
            out_valid   <= 1'b0;
            out_acc     <= '0;
            out_ovf     <= 1'b0;
            proto_err   <= 1'b0;
        end else if (!stall) begin
            v1     <= accept;
            first1 <= in_first;
            last1  <= in_last;
            bias1  <= bias;
            v2     <= v1;
            first2 <= first1;
            last2  <= last1;
            bias2  <= bias1;

            if (v2) begin
                if (beat_err)
                    proto_err <= 1'b1;
                if (last2) begin
                    frame_state <= ST_IDLE;
                    frame_ovf   <= 1'b0;
                    for (int unsigned c = 0; c < N_CH; c++) begin
                        acc[c]                      <= '0;
                        out_acc[c*ACC_W +: ACC_W]   <= res[c];
                    end
                    out_ovf <= frame_ovf_next;
                end else begin
                    frame_state <= ST_OPEN;
                    frame_ovf   <= frame_ovf_next;
                    for (int unsigned c = 0; c < N_CH; c++)
                        acc[c] <= new_acc[c];
                end
            end

            // Not stalled means either nothing is held or the held result is being taken.
            out_valid <= v2 && last2;
        end
    end

endmodule

// File: tb/tb_mac_array_pipe.sv
// Randomised and directed bench for mac_array_pipe with a frame-level
// arithmetic reference model and an in-order result scoreboard.
module tb_mac_array_pipe;

    localparam int N_MACS = 16;
    localparam int N_CH   = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int IW     = N_MACS * DATA_W;
    localparam int WW     = N_CH * N_MACS * DATA_W;
    localparam int BW     = N_CH * ACC_W;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic          sat_en = 1'b0;
    logic          relu_en = 1'b0;
    logic          out_ready = 1'b1;
    logic [IW-1:0] ifmap = '0;
    logic [WW-1:0] weight = '0;
    logic [BW-1:0] bias = '0;
    logic          in_ready;
    logic          out_valid;
    logic [BW-1:0] out_acc;
    logic          out_ovf;
    logic          proto_err;

    always #5 clk = ~clk;

    mac_array_pipe #(
        .N_MACS (N_MACS),
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .ifmap     (ifmap),
        .weight    (weight),
        .bias      (bias),
        .sat_en    (sat_en),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .proto_err (proto_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: whole-frame arithmetic on plain integers.
    typedef struct {
        logic [BW-1:0] acc;
        logic          ovf;
    } exp_t;

    exp_t   exp_q[$];
    bit     m_open = 1'b0;
    bit     m_fovf = 1'b0;
    bit     m_perr = 1'b0;
    longint m_acc [N_CH];

    task automatic model_reset();
        m_open = 1'b0;
        m_fovf = 1'b0;
        m_perr = 1'b0;
        foreach (m_acc[c]) m_acc[c] = 0;
        exp_q.delete();
    endtask

    task automatic model_beat();
        longint           s, base, nv;
        logic signed [7:0] a, w;
        logic signed [31:0] t;
        bit               any_ovf, fovf;
        exp_t             e;
        any_ovf = 1'b0;
        e.acc   = '0;
        if (in_first ? m_open : !m_open) m_perr = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            s = 0;
            for (int i = 0; i < N_MACS; i++) begin
                a = ifmap[i*8 +: 8];
                w = weight[(c*N_MACS+i)*8 +: 8];
                s += longint'(a) * longint'(w);
            end
            if (in_first) begin
                t    = bias[c*32 +: 32];
                base = t;
            end else if (m_open) base = m_acc[c];
            else base = 0;
            nv = base + s;
            if (nv > MAXV || nv < MINV) begin
                any_ovf = 1'b1;
                if (sat_en) nv = (nv > MAXV) ? MAXV : MINV;
                else begin
                    t  = nv[31:0];
                    nv = t;
                end
            end
            m_acc[c] = nv;
            e.acc[c*32 +: 32] = (relu_en && nv < 0) ? 32'd0 : nv[31:0];
        end
        fovf = (in_first ? 1'b0 : m_fovf) | any_ovf;
        if (in_last) begin
            e.ovf = fovf;
            exp_q.push_back(e);
            m_open = 1'b0;
            m_fovf = 1'b0;
        end else begin
            m_open = 1'b1;
            m_fovf = fovf;
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0)
                    check("spurious_out_valid", out_valid, 1'b0);
                else begin
                    check("out_acc", out_acc, exp_q[0].acc);
                    check("out_ovf", out_ovf, exp_q[0].ovf);
                    if (!out_ready) check("in_ready_while_stalled", in_ready, 1'b0);
                    else void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) model_beat();
        end
    end

    function automatic logic [BW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    task automatic fill_const(input int a, input int w);
        for (int i = 0; i < N_MACS; i++) ifmap[i*8 +: 8] = a[7:0];
        for (int j = 0; j < N_CH*N_MACS; j++) weight[j*8 +: 8] = w[7:0];
    endtask

    task automatic fill_random();
        for (int i = 0; i < N_MACS; i++) ifmap[i*8 +: 8] = 8'($urandom);
        for (int j = 0; j < N_CH*N_MACS; j++) weight[j*8 +: 8] = 8'($urandom);
        for (int c = 0; c < N_CH; c++) begin
            case ($urandom_range(0, 2))
                0: bias[c*32 +: 32] = $urandom;
                1: bias[c*32 +: 32] = 32'h7FFF_FFFF - $urandom_range(0, 600000);
                default: bias[c*32 +: 32] = 32'h8000_0000 + $urandom_range(0, 600000);
            endcase
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit first, input bit last);
        int k;
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (k >= 50) check("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [BW-1:0] exp_acc, input logic exp_ovf);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            k++;
            @(negedge clk);
        end
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_acc"}, out_acc, exp_acc);
        check({tag, "_ovf"}, out_ovf, exp_ovf);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        repeat (4) @(posedge clk);
        while (exp_q.size() != 0 && k < 400) begin
            k++;
            @(posedge clk);
        end
        check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    bit rnd_bp = 1'b0;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_acc", out_acc, '0);
        check("reset_out_ovf", out_ovf, 1'b0);
        check("reset_proto_err", proto_err, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        fill_const(2, 3);
        bias = pack4(10, -10, 0, 5);
        send(1, 1);
        wait_out("single_beat", pack4(106, 86, 96, 101), 1'b0);

        send(1, 0);
        send(0, 0);
        send(0, 0);
        send(0, 1);
        wait_out("four_beat", pack4(394, 374, 384, 389), 1'b0);

        fill_const(-128, -128);
        bias = pack4(2147482648, 2147482648, 2147482648, 2147482648);
        sat_en = 1'b1;
        send(1, 1);
        wait_out("saturate", pack4(2147483647, 2147483647, 2147483647, 2147483647), 1'b1);
        sat_en = 1'b0;
        send(1, 1);
        wait_out("wrap", pack4(-2147222504, -2147222504, -2147222504, -2147222504), 1'b1);

        fill_const(1, -1);
        bias = '0;
        relu_en = 1'b1;
        send(1, 1);
        wait_out("relu_on", '0, 1'b0);
        relu_en = 1'b0;
        send(1, 1);
        wait_out("relu_off", pack4(-16, -16, -16, -16), 1'b0);
        check("proto_err_clean", proto_err, 1'b0);

        out_ready = 1'b0;
        fork
            begin
                fill_const(2, 3);
                bias = pack4(10, -10, 0, 5);
                send(1, 1);
                fill_random();
                send(1, 1);
                fill_random();
                send(1, 1);
                fill_random();
                send(1, 1);
            end
            begin
                int k;
                k = 0;
                @(negedge clk);
                while (!out_valid && k < 20) begin
                    k++;
                    @(negedge clk);
                end
                repeat (5) begin
                    check("stall_in_ready", in_ready, 1'b0);
                    check("stall_out_valid", out_valid, 1'b1);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        fill_const(1, 1);
        bias = pack4(1, 2, 3, 4);
        send(1, 0);
        send(0, 0);
        bias = pack4(100, 200, 300, 400);
        send(1, 0);
        send(0, 1);
        wait_out("double_first", pack4(132, 232, 332, 432), 1'b0);
        check("proto_err_double_first", proto_err, 1'b1);
        send(0, 1);
        wait_out("stray_beat", pack4(16, 16, 16, 16), 1'b0);

        fill_const(5, 7);
        send(1, 0);
        send(0, 0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_out_acc", out_acc, '0);
        check("midreset_out_ovf", out_ovf, 1'b0);
        check("midreset_proto_err", proto_err, 1'b0);
        check("midreset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        fill_const(2, 3);
        bias = pack4(10, -10, 0, 5);
        send(1, 1);
        wait_out("after_reset", pack4(106, 86, 96, 101), 1'b0);

        rnd_bp = 1'b1;
        fork
            begin
                while (rnd_bp) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
            begin
                for (int blk = 0; blk < 6; blk++) begin
                    sat_en  = 1'($urandom);
                    relu_en = 1'($urandom);
                    for (int f = 0; f < 6; f++) begin
                        int len;
                        len = $urandom_range(1, 4);
                        for (int b = 0; b < len; b++) begin
                            bit fst;
                            fst = (b == 0);
                            if ($urandom_range(0, 15) == 0) fst = !fst;
                            fill_random();
                            send(fst, b == len - 1);
                        end
                    end
                    drain();
                end
                rnd_bp = 1'b0;
            end
        join
        drain();
        check("proto_err_final", proto_err, m_perr);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
